// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_burst_ctrl                                                  |
// | Purpose  : Burst sequencer for a single-port RAM with a buffered read      |
// |            stream. Define RAM_BURST_CTRL_NOWRAP_EN to reject bursts that   |
// |            would cross the top address (err pulse) instead of wrapping.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ram_burst_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enb,
  output logic              ram_read_enb,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_RD_RESP  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;
  logic              w_reject;

`ifdef RAM_BURST_CTRL_NOWRAP_EN
  logic [ADDR_W:0]   w_end_addr;
  logic              r_err;

  // Carry out of addr+len means the last beat would wrap past the top address.
  assign w_end_addr = {1'b0, req_addr} + {1'b0, req_len};
  assign w_reject   = w_end_addr[ADDR_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_err <= w_reject;
    end
  end

  assign err = (r_state == S_DONE) && r_err;
`else
  assign w_reject = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_data <= w_rd_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_rd_data_nxt = r_rd_data;
    req_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    done          = 1'b0;
    ram_address   = r_ptr;
    ram_data_in   = '0;
    ram_write_enb = 1'b0;
    ram_read_enb  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Held low while reset is asserted so nothing is offered during reset.
        req_ready = reset;
        if (req_valid && reset) begin
          w_ptr_nxt = req_addr;
          w_cnt_nxt = req_len;
          if (w_reject) begin
            w_state_nxt = S_DONE;
          end else if (req_write) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD_ISSUE;
          end
        end
      end

      S_WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_write_enb = 1'b1;
          ram_data_in   = wr_data;
          w_ptr_nxt     = r_ptr + 1'b1;
          w_cnt_nxt     = r_cnt - 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_RD_ISSUE: begin
        ram_read_enb = 1'b1;
        w_state_nxt  = S_RD_CAPT;
      end

      S_RD_CAPT: begin
        // Only cycle in which the RAM output is driven with valid data.
        w_rd_data_nxt = ram_data_out;
        w_state_nxt   = S_RD_RESP;
      end

      S_RD_RESP: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (r_cnt == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_cnt_nxt   = r_cnt - 1'b1;
            w_state_nxt = S_RD_ISSUE;
          end
        end
      end

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_burst_ctrl                                               |
// | Purpose  : Randomised bench for ram_burst_ctrl with a burst-level model    |
// |            and a RAM model; honours RAM_BURST_CTRL_NOWRAP_EN.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ram_burst_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr, req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done, err;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_write_enb, ram_read_enb;
  logic [DATA_W-1:0] ram_data_out;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enb(ram_write_enb), .ram_read_enb(ram_read_enb),
    .ram_data_out(ram_data_out)
  );

  // RAM: registered read; output is garbage in every cycle not following a read.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_enb) ram_mem[ram_address] <= ram_data_in;
    if (ram_read_enb) ram_data_out <= ram_mem[ram_address];
    else              ram_data_out <= 8'($urandom);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Burst-level model: one burst in flight, beat index, read phase within a beat.
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit  busy = 0, is_wr = 0, done_due = 0, due_err = 0, started = 0, prev_rst_low = 0;
  int  base = 0, blen = 0, beat = 0, ph = 0;
  int  cyc = 0, acc_cyc = 0, first_rv_cyc = -1;
  int  we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  logic [DATA_W-1:0] rd_log [$];

  always @(negedge clk) begin : mon
    logic [ADDR_W-1:0] a;
    cyc++;
    a = ADDR_W'(base + beat);
    if (started) begin
      check("req_ready", req_ready, !busy && !done_due && reset);
      check("wr_ready", wr_ready, busy && is_wr);
      check("wr_en", ram_write_enb, busy && is_wr && wr_valid);
      check("rd_en", ram_read_enb, busy && !is_wr && ph == 0);
      check("rd_valid", rd_valid, busy && !is_wr && ph == 2);
      check("done", done, done_due);
      check("err", err, done_due && due_err);
      check("en_excl", ram_write_enb && ram_read_enb, 0);
      if (ram_write_enb || ram_read_enb) check("addr", ram_address, a);
      check("data_in", ram_data_in, ram_write_enb ? wr_data : 8'h00);
      if (rd_valid) check("rd_data", rd_data, model_mem[a]);
      if (prev_rst_low) begin
        check("rst_addr", ram_address, 0);
        check("rst_rd_data", rd_data, 0);
      end
      if (ram_write_enb) we_cnt++;
      if (ram_read_enb) re_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
    end

    if (!reset) begin
      busy = 0; done_due = 0; due_err = 0; started = 1; prev_rst_low = 1;
    end else if (started) begin
      prev_rst_low = 0;
      if (done_due) begin done_due = 0; due_err = 0; end
      if (req_valid && req_ready) begin
        busy = 1; is_wr = req_write; base = req_addr; blen = req_len; beat = 0; ph = 0;
        acc_cnt++; acc_cyc = cyc; first_rv_cyc = -1;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
        if (base + blen > DEPTH - 1) begin busy = 0; done_due = 1; due_err = 1; end
`endif
      end else if (busy && is_wr) begin
        if (wr_valid) begin
          model_mem[a] = wr_data;
          if (beat == blen) begin busy = 0; done_due = 1; end
          else beat++;
        end
      end else if (busy) begin
        if (ph < 2) ph++;
        else if (rd_ready) begin
          rd_log.push_back(rd_data);
          if (beat == blen) begin busy = 0; done_due = 1; end
          else begin beat++; ph = 0; end
        end
      end
    end
  end

  logic [DATA_W-1:0] wbuf [33];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit w, input int addr, input int len);
    int g = 0;
    req_write = w; req_addr = ADDR_W'(addr); req_len = ADDR_W'(len); req_valid = 1;
    while (!req_ready && g < 100) begin step(); g++; end
    if (!req_ready) check("req_timeout", 0, 1);
    step();
    req_valid = 0;
  endtask

  task automatic run_burst(input bit w, input int addr, input int len, input int stall,
                           input bit use_buf, input int hold_beat, input int hold_cycles);
    int b = 0, held = 0, g = 0;
    accept(w, addr, len);
    while (!done && g < 400) begin
      if (w) begin
        wr_valid = use_buf || ($urandom_range(99) >= stall);
        wr_data  = use_buf ? wbuf[b] : 8'($urandom);
        if (wr_valid && wr_ready) b++;
      end else begin
        rd_ready = ($urandom_range(99) >= stall);
        if (rd_valid && b == hold_beat && held < hold_cycles) begin rd_ready = 0; held++; end
        if (rd_valid && rd_ready) b++;
      end
      step(); g++;
    end
    if (!done) check("done_timeout", 0, 1);
    wr_valid = 0; rd_ready = 0;
  endtask

  initial begin
    int w0, r0, d0, e0, a0, g;
    reset = 0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] v;
      v = 8'($urandom);
      ram_mem[i] = v; model_mem[i] = v;
    end
    repeat (3) step();
    reset = 1;
    step();

    // Write 4..6 with A1, B2, C3
    wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3;
    w0 = we_cnt; r0 = re_cnt; d0 = done_cnt;
    run_burst(1, 4, 2, 0, 1, -1, 0);
    step();
    check("t1_we_cnt", we_cnt - w0, 3);
    check("t1_re_cnt", re_cnt - r0, 0);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_mem4", ram_mem[4], 8'hA1);
    check("t1_mem5", ram_mem[5], 8'hB2);
    check("t1_mem6", ram_mem[6], 8'hC3);
    check("t1_model6", model_mem[6], 8'hC3);

    // Read them back at full rate
    rd_log.delete(); d0 = done_cnt;
    run_burst(0, 4, 2, 0, 0, -1, 0);
    step();
    check("t2_len", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("t2_d0", rd_log[0], 8'hA1);
      check("t2_d1", rd_log[1], 8'hB2);
      check("t2_d2", rd_log[2], 8'hC3);
    end
    check("t2_latency", first_rv_cyc - acc_cyc, 3);
    check("t2_done_cnt", done_cnt - d0, 1);

    // Back-pressure on beat 2 for 5 cycles
    rd_log.delete(); r0 = re_cnt;
    run_burst(0, 4, 2, 0, 0, 1, 5);
    step();
    check("t3_re_cnt", re_cnt - r0, 3);
    check("t3_len", rd_log.size(), 3);
    if (rd_log.size() == 3) check("t3_d1", rd_log[1], 8'hB2);

    // Burst crossing the top address
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
    w0 = we_cnt; e0 = err_cnt; d0 = done_cnt;
    run_burst(1, 30, 3, 0, 1, -1, 0);
    step();
    check("t4_done_cnt", done_cnt - d0, 1);
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    check("t4_we_cnt", we_cnt - w0, 0);
    check("t4_err_cnt", err_cnt - e0, 1);
`else
    check("t4_we_cnt", we_cnt - w0, 4);
    check("t4_err_cnt", err_cnt - e0, 0);
    check("t4_mem30", ram_mem[30], 8'h01);
    check("t4_mem31", ram_mem[31], 8'h02);
    check("t4_mem0", ram_mem[0], 8'h03);
    check("t4_mem1", ram_mem[1], 8'h04);
`endif

    // Reset in the middle of a read burst, then a short read
    d0 = done_cnt; rd_ready = 0;
    accept(0, 8, 4);
    g = 0;
    while (!rd_valid && g < 20) begin step(); g++; end
    check("t5_rv_seen", rd_valid, 1);
    reset = 0;
    step();
    reset = 1;
    #1;
    check("t5_rd_valid", rd_valid, 0);
    check("t5_done", done, 0);
    check("t5_req_ready", req_ready, 1);
    rd_log.delete();
    run_burst(0, 0, 0, 0, 0, -1, 0);
    step();
    check("t5_done_cnt", done_cnt - d0, 1);
    check("t5_len", rd_log.size(), 1);

    // req_valid held across two bursts
    a0 = acc_cnt; d0 = done_cnt; g = 0;
    req_write = 1; req_addr = 5'd10; req_len = 5'd1; req_valid = 1; wr_valid = 1;
    while (done_cnt < d0 + 2 && g < 100) begin
      wr_data = 8'($urandom);
      step(); g++;
      if (acc_cnt >= a0 + 2) req_valid = 0;
    end
    req_valid = 0; wr_valid = 0;
    step();
    check("t6_acc_cnt", acc_cnt - a0, 2);
    check("t6_done_cnt", done_cnt - d0, 2);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      run_burst(1'($urandom), $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
                30, 0, -1, 0);
      repeat ($urandom_range(2)) step();
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
